// File: rtl/uart_pkg.sv
// uart_pkg: shared UART arbiter state encoding
package uart_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} tx_state_e;
endpackage

// File: rtl/uart_rr_arbiter.sv
// uart_rr_arbiter: combinational round-robin pick starting at ptr
module uart_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [W-1:0]       ptr,
  output logic [W-1:0]       winner,
  output logic               any_valid
);
  logic [W-1:0] idx;
  assign any_valid = |req_valid;
  // Scan from farthest to nearest offset so the closest valid one wins
  always_comb begin
    winner = '0;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = W'((int'(ptr) + i) % NUM_REQ);
      if (req_valid[idx]) winner = idx;
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin byte arbiter feeding a single UART transmitter
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PACK_SIZE = 8,
  parameter int LAUNCH_TIMEOUT = 16,
  localparam int W = $clog2(NUM_REQ)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0][PACK_SIZE-1:0]  req_data,
  output logic [NUM_REQ-1:0]                 req_ack,
  output logic [NUM_REQ-1:0]                 req_done,
  output logic                               tx_byte_valid,
  output logic [PACK_SIZE-1:0]               tx_byte_data,
  input  logic                               tx_active,
  input  logic                               tx_done,
  output logic [W-1:0]                       grant_id,
  output logic                               busy,
  output logic                               launch_err
);
  localparam int CW = $clog2(LAUNCH_TIMEOUT + 1);
  tx_state_e state, state_d;
  logic [W-1:0] ptr, ptr_d, win, grant_d;
  logic any;
  logic [CW-1:0] cnt, cnt_d;
  logic [PACK_SIZE-1:0] data_d;
  logic [NUM_REQ-1:0] ack_d, done_d;
  logic valid_d, err_d;
  uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_valid(req_valid),
    .ptr(ptr),
    .winner(win),
    .any_valid(any)
  );
  always_comb begin
    state_d = state;
    ptr_d = ptr;
    grant_d = grant_id;
    cnt_d = cnt;
    data_d = tx_byte_data;
    ack_d = '0;
    done_d = '0;
    valid_d = 1'b0;
    err_d = 1'b0;
    case (state)
      IDLE: if (any) begin
        state_d = LAUNCH;
        ptr_d = (win == W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        grant_d = win;
        cnt_d = '0;
        data_d = req_data[win];
        ack_d = NUM_REQ'(1) << win;
        valid_d = 1'b1;
      end
      LAUNCH: if (tx_active) state_d = WAIT_DONE;
        else if (cnt == CW'(LAUNCH_TIMEOUT - 1)) begin
          state_d = IDLE;
          err_d = 1'b1;
        end else begin
          valid_d = 1'b1;
          cnt_d = cnt + 1'b1;
        end
      WAIT_DONE: if (tx_done) begin
        state_d = IDLE;
        done_d = NUM_REQ'(1) << grant_id;
      end
      default: state_d = IDLE;
    endcase
  end
  // Every output is the registered image of its next-state value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      grant_id <= '0;
      cnt <= '0;
      tx_byte_data <= '0;
      tx_byte_valid <= 1'b0;
      req_ack <= '0;
      req_done <= '0;
      launch_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_d;
      ptr <= ptr_d;
      grant_id <= grant_d;
      cnt <= cnt_d;
      tx_byte_data <= data_d;
      tx_byte_valid <= valid_d;
      req_ack <= ack_d;
      req_done <= done_d;
      launch_err <= err_d;
      busy <= state_d != IDLE;
    end
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter PACK_SIZE, default 8, giving the UART data packet width in bits.
REQ-003 The block SHALL have parameter LAUNCH_TIMEOUT, default 16, giving the maximum cycles to wait for tx_active after launch.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port req_valid, input, NUM_REQ bits: per-requester byte request.
REQ-007 The block SHALL have port req_data, input, NUM_REQ x PACK_SIZE bits: per-requester byte.
REQ-008 The block SHALL have port req_ack, output, NUM_REQ bits: one-hot, one-cycle pulse when the byte is latched.
REQ-009 The block SHALL have port req_done, output, NUM_REQ bits: one-hot, one-cycle pulse when the granted byte finishes transmission.
REQ-010 The block SHALL have port tx_byte_valid, output, 1 bit: launch request to the UART transmitter.
REQ-011 The block SHALL have port tx_byte_data, output, PACK_SIZE bits: the latched byte to the transmitter.
REQ-012 The block SHALL have port tx_active, input, 1 bit: transmitter busy, from the UART transmitter.
REQ-013 The block SHALL have port tx_done, input, 1 bit: transmitter frame complete, from the UART transmitter.
REQ-014 The block SHALL have port grant_id, output, clog2(NUM_REQ) bits: index of the current or last granted requester.
REQ-015 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-016 The block SHALL have port launch_err, output, 1 bit: one-cycle pulse on launch timeout.

Function
REQ-017 The FSM SHALL have exactly three states, IDLE, LAUNCH and WAIT_DONE, and SHALL reset to IDLE.
REQ-018 In IDLE with any req_valid high, the block SHALL pick a winner round-robin starting from the priority pointer, latch its req_data into tx_byte_data, set grant_id, and move to LAUNCH at that edge.
REQ-019 In the first cycle of LAUNCH, the block SHALL pulse req_ack[winner] for exactly one cycle and SHALL drive tx_byte_valid=1, so both appear one cycle after req_valid is sampled.
REQ-020 The priority pointer SHALL be set to (winner+1) mod NUM_REQ at the grant edge, so a requester holding req_valid cannot win twice while another requester is waiting.
REQ-021 In LAUNCH, tx_byte_valid SHALL stay high until tx_active is sampled high; the block SHALL then drop tx_byte_valid and move to WAIT_DONE.
REQ-022 In LAUNCH, a counter SHALL count cycles; if LAUNCH_TIMEOUT cycles elapse without tx_active, the block SHALL drop tx_byte_valid, pulse launch_err for one cycle, and return to IDLE with no req_done.
REQ-023 In WAIT_DONE, when tx_done is sampled high, the block SHALL pulse req_done[grant_id] for one cycle and return to IDLE.
REQ-024 After a return to IDLE, the block SHALL spend at least one cycle in IDLE before the next grant, even if tx_done and req_valid are high together.
REQ-025 tx_active and tx_done SHALL be ignored while the FSM is in IDLE.
REQ-026 The block SHALL latch req_data only at the grant edge; later changes on req_data SHALL not affect tx_byte_data.
REQ-027 A requester SHALL hold req_valid and req_data stable until it sees req_ack; deasserting req_valid before req_ack withdraws the request without error.
REQ-028 tx_byte_data SHALL hold its value after the frame until the next grant.

Reset
REQ-029 On rst high, immediately and regardless of clk, the block SHALL set state=IDLE, priority pointer=0, grant_id=0, tx_byte_data=0, and tx_byte_valid, busy, launch_err, req_ack and req_done all to 0.
REQ-030 On reset mid-operation, the block SHALL abandon the in-flight byte and SHALL not issue req_done for it.
REQ-031 The first grant after reset release SHALL favour requester 0.

Structure
REQ-032 The FSM state enum and any shared UART constants SHALL live in the shared package uart_pkg.
REQ-033 The round-robin pick SHALL be a sub-module uart_rr_arbiter: combinational, taking req_valid and the pointer and returning the winner index and an any-valid flag.
REQ-034 All outputs SHALL be registered.

Verification
REQ-035 Single request: NUM_REQ=4, req_valid=4'b0100, req_data[2]=8'hA5 -> req_ack=4'b0100 and tx_byte_valid=1 one cycle later; tx_byte_data=8'hA5; req_done=4'b0100 after tx_done.
REQ-036 Round-robin fairness: all four req_valid held high, each acked request re-asserted -> grant_id sequence 0,1,2,3,0.
REQ-037 Loopback: the block drives the UART transmitter (CLK_PER_BIT=10) looped back to the receiver, requester 1 sends 8'hFE -> the receiver outputs 8'hFE, par_error=0, req_done[1] pulses.
REQ-038 Launch timeout: tx_active tied 0, LAUNCH_TIMEOUT=16 -> launch_err pulses 16 cycles after launch, tx_byte_valid drops, no req_done, busy=0 next cycle.
REQ-039 Back-to-back: tx_done coincides with a pending request -> exactly one IDLE cycle, then a new req_ack for the next requester in round-robin order.
REQ-040 Reset mid-frame: rst pulsed during WAIT_DONE -> all outputs 0 immediately, no req_done, and the next grant goes to requester 0.
